// File: rtl/opt_decryptor.sv
// Byte-stream decryptor: XOR with a per-frame LFSR keystream, then rotate right by one.
// Plaintext leaves on a registered valid/ready port that sustains one byte per cycle.
module opt_decryptor #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       key_load,
  input  logic [7:0] key,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] byte_cnt
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [7:0] LastCnt = 8'(FRAME_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] seed_q, seed_d;
  logic [7:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       frame_done_q, frame_done_d;

  logic       in_xfer;
  logic       out_xfer;
  logic [7:0] mixed;
  logic [7:0] key_seed;

  assign in_ready = ena & (state_q == StRun) & ~key_load & (~out_valid_q | out_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready & ena;
  assign mixed    = in_data ^ lfsr_q;
  // A zero seed would lock the LFSR at zero forever.
  assign key_seed = (key == 8'h00) ? 8'h01 : key;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    seed_d       = seed_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = frame_done_q;
    if (ena) begin
      frame_done_d = 1'b0;
      if (key_load) begin
        state_d = StRun;
        seed_d  = key_seed;
        lfsr_d  = key_seed;
        cnt_d   = 8'h00;
      end else if (in_xfer) begin
        out_data_d  = {mixed[0], mixed[7:1]};
        out_valid_d = 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d        = 8'h00;
          lfsr_d       = seed_q;
          frame_done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
      end
      if (out_xfer && !in_xfer) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lfsr_q       <= 8'h01;
      seed_q       <= 8'h01;
      cnt_q        <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      seed_q       <= seed_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_opt_decryptor.sv
// Self-checking bench for opt_decryptor: a reference model pushes expected bytes to a
// scoreboard on acceptance and a monitor pops them when the DUT presents them.
module tb_opt_decryptor;

  localparam int unsigned FL = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, key_load, in_valid, out_ready;
  logic [7:0] key, in_data;
  logic       in_ready, out_valid, frame_done;
  logic [7:0] out_data, byte_cnt;

  always #5 clk = ~clk;

  opt_decryptor #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .key_load   (key_load),
    .key        (key),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .byte_cnt   (byte_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       fd;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic       m_run, m_ov, mon_new;
  logic [7:0] m_seed, m_lfsr, m_cnt, m_od, last_data;

  task automatic model_reset();
    m_run  = 1'b0;
    m_ov   = 1'b0;
    m_seed = 8'h01;
    m_lfsr = 8'h01;
    m_cnt  = 8'h00;
    m_od   = 8'h00;
  endtask

  // One clock with the inputs the caller set; ends 1 time unit after the edge.
  task automatic step();
    logic       exp_ir, ixfer, oxfer, fd;
    logic [7:0] x, pd, ncnt;
    #1;
    exp_ir = ena & m_run & ~key_load & (~m_ov | out_ready);
    checks++;
    if (in_ready !== exp_ir) begin
      failures++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ir, $time);
    end
    ixfer = in_valid & exp_ir & rst_n;
    oxfer = m_ov & out_ready & ena;
    x     = in_data ^ m_lfsr;
    pd    = {x[0], x[7:1]};
    fd    = (m_cnt == 8'(FL - 1));
    ncnt  = fd ? 8'h00 : m_cnt + 8'd1;
    if (ixfer) begin
      sb.push_back('{data: pd, fd: fd, cnt: ncnt});
      last_data = pd;
    end
    mon_new = ixfer;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      sb.delete();
    end else if (ena) begin
      if (key_load) begin
        m_run  = 1'b1;
        m_seed = (key == 8'h00) ? 8'h01 : key;
        m_lfsr = m_seed;
        m_cnt  = 8'h00;
      end else if (ixfer) begin
        m_lfsr = fd ? m_seed : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_cnt  = ncnt;
      end
      if (ixfer) begin
        m_ov = 1'b1;
        m_od = pd;
      end else if (oxfer) begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  // Scoreboard monitor: a new byte must appear exactly one cycle after acceptance.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_new) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: scoreboard empty at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || out_data !== e.data || frame_done !== e.fd ||
            byte_cnt !== e.cnt) begin
          failures++;
          $display("FAIL sb_byte: got v=%b d=%h fd=%b cnt=%0d expected v=1 d=%h fd=%b cnt=%0d",
                   out_valid, out_data, frame_done, byte_cnt, e.data, e.fd, e.cnt);
        end
      end
    end else begin
      checks++;
      if (out_valid !== m_ov || frame_done !== 1'b0 || byte_cnt !== m_cnt ||
          (m_ov && out_data !== m_od)) begin
        failures++;
        $display("FAIL hold: got v=%b d=%h fd=%b cnt=%0d expected v=%b d=%h fd=0 cnt=%0d at %0t",
                 out_valid, out_data, frame_done, byte_cnt, m_ov, m_od, m_cnt, $time);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; key_load = 1'b0; key = 8'h00;
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0 || byte_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle: v=%b d=%h rdy=%b cnt=%0d expected 0/00/0/0",
               out_valid, out_data, in_ready, byte_cnt);
    end
  endtask

  task automatic test_basic();
    key = 8'h01; key_load = 1'b1; in_valid = 1'b0;
    step();
    key_load = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    step();
    checks++;
    if (out_data !== 8'h7F || byte_cnt !== 8'd1) begin
      failures++;
      $display("FAIL basic_ff: d=%h cnt=%0d expected 7f 1", out_data, byte_cnt);
    end
    in_data = 8'h02;
    step();
    checks++;
    if (out_data !== 8'h00 || byte_cnt !== 8'd2) begin
      failures++;
      $display("FAIL basic_02: d=%h cnt=%0d expected 00 2", out_data, byte_cnt);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_key();
    key = 8'h00; key_load = 1'b1; in_valid = 1'b0;
    step();
    key_load = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    step();
    checks++;
    if (out_data !== 8'h7F) begin
      failures++;
      $display("FAIL zero_key: d=%h expected 7f", out_data);
    end
    in_data = 8'h00;
    for (int i = 0; i < 300; i++) begin
      step();
      checks++;
      if (out_data === 8'h00) begin
        failures++;
        $display("FAIL lfsr_nonzero: byte %0d keystream zero", i);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_enable();
    logic [7:0] held;
    key = 8'h77; key_load = 1'b1; in_valid = 1'b1; in_data = 8'h12;
    step();
    key_load = 1'b0;
    step();
    held = out_data;
    ena = 1'b0; in_data = 8'h34;
    repeat (3) step();
    checks++;
    if (out_data !== held || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ena_hold: d=%h v=%b expected %h 1", out_data, out_valid, held);
    end
    ena = 1'b1; in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    key = 8'h5A; key_load = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    key_load = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
    step();
    held = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_data !== held || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall: rdy=%b d=%h v=%b expected 0 %h 1",
                 in_ready, out_data, out_valid, held);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_frame_wrap();
    logic [7:0] cin[5];
    logic [7:0] cexp[5];
    logic       fexp[5];
    cin  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
    cexp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    fexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    key = 8'h01; key_load = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    key_load = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = cin[i];
      step();
      checks++;
      if (out_data !== 8'h00 || byte_cnt !== cexp[i] || frame_done !== fexp[i]) begin
        failures++;
        $display("FAIL frame_wrap[%0d]: d=%h cnt=%0d fd=%b expected 00 %0d %b",
                 i, out_data, byte_cnt, frame_done, cexp[i], fexp[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_collision_reset();
    key = 8'h35; key_load = 1'b1; in_valid = 1'b1; in_data = 8'h35;
    step();
    key_load = 1'b0;
    step();
    checks++;
    if (out_data !== 8'h00 || byte_cnt !== 8'd1) begin
      failures++;
      $display("FAIL collision: d=%h cnt=%0d expected 00 1", out_data, byte_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop: v=%b expected 0", out_valid);
    end
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle2: rdy=%b v=%b expected 0 0", in_ready, out_valid);
    end
    key = 8'h01; key_load = 1'b1;
    step();
    key_load = 1'b0; in_data = 8'hFF;
    step();
    checks++;
    if (out_data !== 8'h7F) begin
      failures++;
      $display("FAIL reload: d=%h expected 7f", out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    mon_new   = 1'b0;
    last_data = 8'h00;
    test_reset();
    test_basic();
    test_zero_key();
    test_enable();
    test_backpressure();
    test_frame_wrap();
    test_collision_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d bytes never produced", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
